// File: rtl/m3_phase_gate_driver.sv
// Three-phase gate driver: 12-step commutation with high-side PWM and per-phase dead-time insertion.
// Optional M3_BRAKE_EN: force-stop turns on all low sides (active brake) instead of turning all gates off.
module m3_phase_gate_driver #(
    parameter int PWM_BITS  = 8,
    parameter int DEAD_TIME = 4,
    parameter int DT_BITS   = 4
) (
    input  logic                clkI,
    input  logic                nRstI,
    input  logic [3:0]          m3stepI,
    input  logic [PWM_BITS-1:0] m3dutyI,
    input  logic                m3invRotateI,
    input  logic                m3forceStopI,
    output logic                m3gateAhO,
    output logic                m3gateAlO,
    output logic                m3gateBhO,
    output logic                m3gateBlO,
    output logic                m3gateChO,
    output logic                m3gateClO,
    output logic                m3pwmSyncO,
    output logic                m3activeO
);

    typedef enum logic [1:0] {PH_Z, PH_H, PH_L} phase_t;
    typedef enum logic {SIDE_LO, SIDE_HI} side_t;

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam logic [DT_BITS-1:0]  DT_LOAD = DT_BITS'(DEAD_TIME);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                sync_q, sync_d;
    logic                active_q, active_d;
    logic                pwm_on;
    logic                step_valid;

    logic [3:0]          pos_lag, pos_lead;
    logic [3:0]          pos [3];
    logic [2:0]          req_hi, req_lo;

    logic [2:0]          hi_q, hi_d;
    logic [2:0]          lo_q, lo_d;
    logic [DT_BITS-1:0]  dt_q [3];
    logic [DT_BITS-1:0]  dt_d [3];
    side_t               last_q [3];
    side_t               last_d [3];

    // Commutation position to drive state: 0..4 high, 5 float, 6..10 low, 11 float.
    function automatic phase_t pos_state(input logic [3:0] p);
        phase_t s;
        if (p <= 4'd4)       s = PH_H;
        else if (p == 4'd5)  s = PH_Z;
        else if (p <= 4'd10) s = PH_L;
        else                 s = PH_Z;
        return s;
    endfunction

    always_comb begin
        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        duty_d     = (pwm_cnt_q == PWM_MAX) ? m3dutyI : duty_q;
        sync_d     = (pwm_cnt_q == PWM_MAX);
        pwm_on     = (pwm_cnt_q < duty_q);
        step_valid = (m3stepI < 4'd12);
        active_d   = step_valid & ~m3forceStopI;
    end

    always_comb begin
        pos_lag  = (m3stepI >= 4'd4) ? (m3stepI - 4'd4) : (m3stepI + 4'd8);
        pos_lead = (m3stepI >= 4'd8) ? (m3stepI - 4'd8) : (m3stepI + 4'd4);
        pos[0]   = m3stepI;
        pos[1]   = m3invRotateI ? pos_lead : pos_lag;
        pos[2]   = m3invRotateI ? pos_lag  : pos_lead;
    end

    always_comb begin
        req_hi = '0;
        req_lo = '0;
        for (int ph = 0; ph < 3; ph++) begin
            if (m3forceStopI) begin
`ifdef M3_BRAKE_EN
                req_lo[ph] = 1'b1;
`else
                req_lo[ph] = 1'b0;
`endif
            end else if (step_valid) begin
                case (pos_state(pos[ph]))
                    PH_H:    req_hi[ph] = pwm_on;
                    PH_L:    req_lo[ph] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // A side may switch on only when the opposite gate is off and either the
    // dead-time has expired or this same side was the last one to turn off.
    always_comb begin
        hi_d = '0;
        lo_d = '0;
        for (int ph = 0; ph < 3; ph++) begin
            dt_d[ph]   = dt_q[ph];
            last_d[ph] = last_q[ph];
            hi_d[ph] = req_hi[ph] & ~lo_q[ph] &
                       ((dt_q[ph] == '0) | (last_q[ph] == SIDE_HI));
            lo_d[ph] = req_lo[ph] & ~hi_q[ph] &
                       ((dt_q[ph] == '0) | (last_q[ph] == SIDE_LO));
            if (hi_q[ph] & ~hi_d[ph]) begin
                dt_d[ph]   = DT_LOAD;
                last_d[ph] = SIDE_HI;
            end else if (lo_q[ph] & ~lo_d[ph]) begin
                dt_d[ph]   = DT_LOAD;
                last_d[ph] = SIDE_LO;
            end else if (dt_q[ph] != '0) begin
                dt_d[ph]   = dt_q[ph] - DT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clkI or negedge nRstI) begin
        if (!nRstI) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
            sync_q    <= 1'b0;
            active_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            for (int ph = 0; ph < 3; ph++) begin
                dt_q[ph]   <= '0;
                last_q[ph] <= SIDE_LO;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
            sync_q    <= sync_d;
            active_q  <= active_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            for (int ph = 0; ph < 3; ph++) begin
                dt_q[ph]   <= dt_d[ph];
                last_q[ph] <= last_d[ph];
            end
        end
    end

    assign m3gateAhO  = hi_q[0];
    assign m3gateAlO  = lo_q[0];
    assign m3gateBhO  = hi_q[1];
    assign m3gateBlO  = lo_q[1];
    assign m3gateChO  = hi_q[2];
    assign m3gateClO  = lo_q[2];
    assign m3pwmSyncO = sync_q;
    assign m3activeO  = active_q;

endmodule

// File: tb/tb_m3_phase_gate_driver.sv
// Directed bench for m3_phase_gate_driver: per-step gate duty table plus dead-time, duty-latch, stop and reset sequences.
`timescale 1ns/1ps
module tb_m3_phase_gate_driver;

    logic       clkI = 1'b0;
    logic       nRstI = 1'b0;
    logic [3:0] m3stepI = 4'hF;
    logic [7:0] m3dutyI = 8'd0;
    logic       m3invRotateI = 1'b0;
    logic       m3forceStopI = 1'b0;
    logic       m3gateAhO, m3gateAlO, m3gateBhO, m3gateBlO, m3gateChO, m3gateClO;
    logic       m3pwmSyncO, m3activeO;

    int checks = 0;
    int errors = 0;
    int shoot  = 0;
    int cnt [6];

    typedef struct {
        logic [3:0] step;
        logic       inv;
        logic       stop;
        logic [7:0] duty;
        int         ah, al, bh, bl, ch, cl;
        logic       act;
    } vec_t;

    vec_t vecs [12];

    m3_phase_gate_driver #(.PWM_BITS(8), .DEAD_TIME(4), .DT_BITS(4)) dut (
        .clkI(clkI), .nRstI(nRstI), .m3stepI(m3stepI), .m3dutyI(m3dutyI),
        .m3invRotateI(m3invRotateI), .m3forceStopI(m3forceStopI),
        .m3gateAhO(m3gateAhO), .m3gateAlO(m3gateAlO),
        .m3gateBhO(m3gateBhO), .m3gateBlO(m3gateBlO),
        .m3gateChO(m3gateChO), .m3gateClO(m3gateClO),
        .m3pwmSyncO(m3pwmSyncO), .m3activeO(m3activeO)
    );

    always #500 clkI = ~clkI;

    always @(negedge clkI)
        if (nRstI && ((m3gateAhO & m3gateAlO) | (m3gateBhO & m3gateBlO) | (m3gateChO & m3gateClO)))
            shoot++;

    function automatic logic [5:0] gates();
        return {m3gateAhO, m3gateAlO, m3gateBhO, m3gateBlO, m3gateChO, m3gateClO};
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sync(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clkI);
            n++;
        end while (!m3pwmSyncO && n < 600);
        if (!m3pwmSyncO) begin
            checks++;
            errors++;
            $display("FAIL %s: no pwm sync within %0d clocks", name, n);
        end
    endtask

    task automatic count_window(input int n);
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clkI);
            cnt[0] += int'(m3gateAhO);
            cnt[1] += int'(m3gateAlO);
            cnt[2] += int'(m3gateBhO);
            cnt[3] += int'(m3gateBlO);
            cnt[4] += int'(m3gateChO);
            cnt[5] += int'(m3gateClO);
        end
    endtask

    initial begin
        int n;
        int both;

        // step inv stop duty | Ah Al Bh Bl Ch Cl (counts per 256 clocks) | active
        vecs[0]  = '{4'd0,  1'b0, 1'b0, 8'd128, 128, 0,   0,   256, 128, 0,   1'b1};
        vecs[1]  = '{4'd0,  1'b1, 1'b0, 8'd128, 128, 0,   128, 0,   0,   256, 1'b1};
        vecs[2]  = '{4'd5,  1'b0, 1'b0, 8'd64,  0,   0,   64,  0,   0,   256, 1'b1};
        vecs[3]  = '{4'd11, 1'b0, 1'b0, 8'd200, 0,   0,   0,   256, 200, 0,   1'b1};
        vecs[4]  = '{4'd6,  1'b0, 1'b0, 8'd0,   0,   256, 0,   0,   0,   256, 1'b1};
        vecs[5]  = '{4'd8,  1'b0, 1'b0, 8'd255, 0,   256, 255, 0,   255, 0,   1'b1};
        vecs[6]  = '{4'd3,  1'b1, 1'b0, 8'd100, 100, 0,   0,   256, 0,   0,   1'b1};
        vecs[7]  = '{4'd15, 1'b0, 1'b0, 8'd128, 0,   0,   0,   0,   0,   0,   1'b0};
        vecs[8]  = '{4'd12, 1'b0, 1'b0, 8'd128, 0,   0,   0,   0,   0,   0,   1'b0};
`ifdef M3_BRAKE_EN
        vecs[9]  = '{4'd2,  1'b0, 1'b1, 8'd128, 0,   256, 0,   256, 0,   256, 1'b0};
`else
        vecs[9]  = '{4'd2,  1'b0, 1'b1, 8'd128, 0,   0,   0,   0,   0,   0,   1'b0};
`endif
        vecs[10] = '{4'd9,  1'b0, 1'b0, 8'd1,   0,   256, 0,   0,   1,   0,   1'b1};
        vecs[11] = '{4'd10, 1'b1, 1'b0, 8'd50,  0,   256, 50,  0,   0,   256, 1'b1};

        repeat (3) @(negedge clkI);
        check_int("reset_gates", int'(gates()), 0);
        check_int("reset_active", int'(m3activeO), 0);
        check_int("reset_sync", int'(m3pwmSyncO), 0);

        nRstI = 1'b1;
        n = 0;
        do begin
            @(negedge clkI);
            n++;
        end while (!m3pwmSyncO && n < 600);
        check_int("first_sync_latency", n, 256);
        @(negedge clkI);
        check_int("sync_pulse_width", int'(m3pwmSyncO), 0);
        n = 1;
        while (!m3pwmSyncO && n < 600) begin
            @(negedge clkI);
            n++;
        end
        check_int("sync_period", n, 256);
        check_int("idle_active", int'(m3activeO), 0);

        for (int v = 0; v < 12; v++) begin
            @(negedge clkI);
            m3stepI      = vecs[v].step;
            m3invRotateI = vecs[v].inv;
            m3forceStopI = vecs[v].stop;
            m3dutyI      = vecs[v].duty;
            wait_sync("vec_sync");
            wait_sync("vec_sync");
            count_window(256);
            check_int($sformatf("vec%0d_ah", v), cnt[0], vecs[v].ah);
            check_int($sformatf("vec%0d_al", v), cnt[1], vecs[v].al);
            check_int($sformatf("vec%0d_bh", v), cnt[2], vecs[v].bh);
            check_int($sformatf("vec%0d_bl", v), cnt[3], vecs[v].bl);
            check_int($sformatf("vec%0d_ch", v), cnt[4], vecs[v].ch);
            check_int($sformatf("vec%0d_cl", v), cnt[5], vecs[v].cl);
            check_int($sformatf("vec%0d_active", v), int'(m3activeO), int'(vecs[v].act));
        end

        // duty change in mid-period only takes effect from the next period
        @(negedge clkI);
        m3stepI = 4'd0; m3invRotateI = 1'b0; m3forceStopI = 1'b0; m3dutyI = 8'd10;
        wait_sync("duty_sync");
        wait_sync("duty_sync");
        for (int k = 0; k < 6; k++) cnt[k] = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clkI);
            if (i == 50) m3dutyI = 8'd200;
            cnt[0] += int'(m3gateAhO);
        end
        check_int("duty_old_period", cnt[0], 10);
        @(negedge clkI);
        check_int("duty_next_sync", int'(m3pwmSyncO), 1);
        count_window(256);
        check_int("duty_new_period", cnt[0], 200);

        // high-to-low side change on phase A: exactly DEAD_TIME+1 clocks both off
        m3dutyI = 8'd255;
        m3stepI = 4'd4;
        wait_sync("dt_sync");
        wait_sync("dt_sync");
        repeat (10) @(negedge clkI);
        check_int("dt_pre_ah", int'(m3gateAhO), 1);
        m3stepI = 4'd6;
        both = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clkI);
            if (i == 0) check_int("dt_ah_fall", int'(m3gateAhO), 0);
            if (m3gateAlO) break;
            if (!m3gateAhO) both++;
        end
        check_int("dt_gap", both, 5);
        check_int("dt_al_on", int'(m3gateAlO), 1);

        // force-stop while running
        m3stepI = 4'd0;
        wait_sync("stop_sync");
        wait_sync("stop_sync");
        repeat (10) @(negedge clkI);
        check_int("stop_pre_gates", int'(gates()), int'(6'b100110));
        m3forceStopI = 1'b1;
        @(negedge clkI);
        check_int("stop_active", int'(m3activeO), 0);
`ifdef M3_BRAKE_EN
        check_int("brake_e1", int'(gates()), int'(6'b000100));
        repeat (4) @(negedge clkI);
        check_int("brake_e5", int'(gates()), int'(6'b000100));
        @(negedge clkI);
        check_int("brake_e6", int'(gates()), int'(6'b010101));
`else
        check_int("stop_e1", int'(gates()), 0);
        repeat (5) @(negedge clkI);
        check_int("stop_e6", int'(gates()), 0);
`endif

        // asynchronous reset mid-operation
        m3forceStopI = 1'b0;
        m3stepI = 4'd6;
        repeat (20) @(negedge clkI);
        check_int("rst_pre_al", int'(m3gateAlO), 1);
        #200;
        nRstI = 1'b0;
        #1;
        check_int("async_rst_gates", int'(gates()), 0);
        check_int("async_rst_active", int'(m3activeO), 0);
        @(negedge clkI);
        nRstI = 1'b1;
        @(negedge clkI);
        check_int("post_rst_al", int'(m3gateAlO), 1);
        repeat (5) @(negedge clkI);

        check_int("shoot_through", shoot, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
